serial_link_ctrl: RTL and testbench



---
 rtl/serial_link_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_serial_link_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_ctrl.sv
// serial_link_ctrl: moves host bytes through the serial port's SB/SC
// registers, borrowing the shared I/O bus only around register accesses.
module serial_link_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000,
  parameter logic [1:0]  SC_CTRL        = 2'b01
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [7:0]  I_TX_DATA,
  input  logic        I_TX_VALID,
  output logic        O_TX_READY,
  output logic [7:0]  O_RX_DATA,
  output logic        O_RX_VALID,
  input  logic        I_RX_READY,
  output logic        O_BUS_REQ,
  input  logic        I_BUS_GRANT,
  output logic [15:0] O_ADDR_BUS,
  inout  wire  [7:0]  IO_DATA_BUS,
  output logic        O_WE_BUS_L,
  output logic        O_RE_BUS_L,
  input  logic        I_SERIAL_INTERRUPT,
  output logic        O_BUSY,
  output logic        O_TIMEOUT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [15:0] SB_ADDR = 16'hFF01;
  localparam logic [15:0] SC_ADDR = 16'hFF02;
  localparam logic [7:0]  SC_START = {1'b1, 5'b11111, SC_CTRL};
  localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

  typedef enum logic [2:0] {
    IDLE,
    REQ_W,
    WR_SB,
    WR_SC,
    WAIT,
    REQ_R,
    RD_SB
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_q;
  logic [AW:0] tx_rd_q;
  logic [AW:0] rx_wr_q;
  logic [AW:0] rx_rd_q;

  logic tx_empty;
  logic tx_full;
  logic rx_empty;
  logic rx_full;
  logic tx_push;
  logic tx_pop;
  logic rx_push;
  logic rx_pop;

  logic [15:0] tmo_cnt_q;
  logic        tmo_q;
  logic        tmo_d;

  logic       we_slot;
  logic       re_slot;
  logic       wr_drive;
  logic [7:0] wr_data;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                    (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                    (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  assign tx_push = I_TX_VALID && !tx_full;
  assign tx_pop  = (state_q == WR_SB) && I_BUS_GRANT;
  assign rx_push = (state_q == RD_SB) && I_BUS_GRANT;
  assign rx_pop  = !rx_empty && I_RX_READY;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PTR_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= I_TX_DATA;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PTR_ONE;
      if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= IO_DATA_BUS;
  end

  // Counter only runs in WAIT, so it is zero on every WAIT entry.
  always_ff @(posedge I_CLK) begin
    if (I_RESET || state_q != WAIT) tmo_cnt_q <= '0;
    else                            tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= IDLE;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // RX space is reserved before starting so the read-back never drops.
  always_comb begin
    state_d = state_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE:  if (!tx_empty && !rx_full) state_d = REQ_W;
      REQ_W: if (I_BUS_GRANT) state_d = WR_SB;
      WR_SB: if (I_BUS_GRANT) state_d = WR_SC;
      WR_SC: if (I_BUS_GRANT) state_d = WAIT;
      WAIT: begin
        if (I_SERIAL_INTERRUPT) begin
          state_d = REQ_R;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      REQ_R: if (I_BUS_GRANT) state_d = RD_SB;
      RD_SB: if (I_BUS_GRANT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    O_BUS_REQ  = 1'b0;
    O_ADDR_BUS = '0;
    wr_data    = '0;
    we_slot    = 1'b0;
    re_slot    = 1'b0;
    unique case (state_q)
      REQ_W, REQ_R: O_BUS_REQ = 1'b1;
      WR_SB: begin
        O_BUS_REQ  = 1'b1;
        O_ADDR_BUS = SB_ADDR;
        wr_data    = tx_mem[tx_rd_q[AW-1:0]];
        we_slot    = 1'b1;
      end
      WR_SC: begin
        O_BUS_REQ  = 1'b1;
        O_ADDR_BUS = SC_ADDR;
        wr_data    = SC_START;
        we_slot    = 1'b1;
      end
      RD_SB: begin
        O_BUS_REQ  = 1'b1;
        O_ADDR_BUS = SB_ADDR;
        re_slot    = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_drive    = we_slot && I_BUS_GRANT;
  assign O_WE_BUS_L  = !wr_drive;
  assign O_RE_BUS_L  = !(re_slot && I_BUS_GRANT);
  assign IO_DATA_BUS = wr_drive ? wr_data : 8'hzz;

  assign O_TX_READY = !tx_full;
  assign O_RX_VALID = !rx_empty;
  assign O_RX_DATA  = rx_empty ? 8'h00 : rx_mem[rx_rd_q[AW-1:0]];
  assign O_BUSY     = (state_q != IDLE);
  assign O_TIMEOUT  = tmo_q;

endmodule

// File: tb/tb_serial_link_ctrl.sv
// tb_serial_link_ctrl: directed and random traffic against a
// transaction-level model of the host FIFOs and the serial port.
`timescale 1ns/1ps
module tb_serial_link_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam logic [7:0] SC_EXP = {1'b1, 5'b11111, 2'b01};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        bus_req;
  logic        grant = 1'b0;
  logic [15:0] addr;
  wire  [7:0]  bus;
  logic        we_l;
  logic        re_l;
  logic        irq;
  logic        busy;
  logic        tmo;
  logic        man_irq = 1'b0;
  logic        irq_auto = 1'b0;
  logic [7:0]  rd_val = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  int d_q[$];
  int rd_q[$];
  int irq_at = -1;
  int tmo_at = -1;
  bit xfer_active = 0;
  bit read_exp = 0;
  bit wr_phase = 0;
  int wr01_n = 0, wr02_n = 0, rd_n = 0;
  int tmo_n = 0, req_n = 0, accepted = 0;
  int wr01_cyc = 0, wr02_cyc = 0;

  serial_link_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(16'(TMO)),
    .SC_CTRL(2'b01)
  ) dut (
    .I_CLK(clk),
    .I_RESET(rst),
    .I_TX_DATA(tx_data),
    .I_TX_VALID(tx_valid),
    .O_TX_READY(tx_ready),
    .O_RX_DATA(rx_data),
    .O_RX_VALID(rx_valid),
    .I_RX_READY(rx_ready),
    .O_BUS_REQ(bus_req),
    .I_BUS_GRANT(grant),
    .O_ADDR_BUS(addr),
    .IO_DATA_BUS(bus),
    .O_WE_BUS_L(we_l),
    .O_RE_BUS_L(re_l),
    .I_SERIAL_INTERRUPT(irq),
    .O_BUSY(busy),
    .O_TIMEOUT(tmo)
  );

  always #5 clk = ~clk;

  // Serial port model: returns the exchanged byte on an SB read.
  assign bus = !re_l ? rd_val : 8'hzz;
  assign irq = irq_auto | man_irq;

  always @(posedge clk) begin
    cyc++;
    #1 irq_auto = (cyc == irq_at);
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int d;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      irq_at = -1;
      tmo_at = -1;
      xfer_active = 0;
      read_exp = 0;
      wr_phase = 0;
    end else begin
      check("tx_ready", tx_ready, m_tx.size() < DEPTH);
      check("rx_valid", rx_valid, m_rx.size() != 0);
      if (m_rx.size() != 0) check("rx_data", rx_data, m_rx[0]);
      check("timeout", tmo, cyc == tmo_at);
      if (tmo) tmo_n++;
      if (bus_req) req_n++;
      if (!grant) begin
        check("we_ungranted", we_l, 1);
        check("re_ungranted", re_l, 1);
      end
      if (!we_l) begin
        check("wr_addr", addr, wr_phase ? 16'hFF02 : 16'hFF01);
        if (!wr_phase) begin
          if (m_tx.size() == 0) begin
            check("tx_underrun", m_tx.size(), 1);
          end else begin
            check("sb_byte", bus, m_tx[0]);
            void'(m_tx.pop_front());
          end
          wr01_n++;
          wr01_cyc = cyc;
          wr_phase = 1;
        end else begin
          check("sc_byte", bus, SC_EXP);
          wr02_n++;
          wr02_cyc = cyc;
          wr_phase = 0;
          d = (d_q.size() != 0) ? d_q.pop_front()
                                : int'($urandom_range(18, 0));
          rd_val = (rd_q.size() != 0) ? 8'(rd_q.pop_front())
                                      : 8'($urandom);
          irq_at = cyc + 1 + d;
          read_exp = (d < TMO);
          tmo_at = read_exp ? -1 : cyc + 1 + TMO;
          xfer_active = 1;
        end
      end
      if (!re_l) begin
        check("rd_addr", addr, 16'hFF01);
        check("rd_expected", read_exp, 1);
        rd_n++;
        read_exp = 0;
        xfer_active = 0;
        irq_at = -1;
      end
      if (xfer_active && !read_exp && cyc >= irq_at
          && cyc >= tmo_at) begin
        xfer_active = 0;
        irq_at = -1;
        tmo_at = -1;
      end
      if (rx_valid && rx_ready && m_rx.size() != 0)
        void'(m_rx.pop_front());
      if (!re_l) m_rx.push_back(rd_val);
      if (tx_valid && tx_ready) begin
        m_tx.push_back(tx_data);
        accepted++;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic push(logic [7:0] b);
    int a0 = accepted;
    int k = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (accepted == a0 && k < 200) begin
      step(1);
      k++;
    end
    tx_valid = 1'b0;
    check("push_accept", accepted, a0 + 1);
  endtask

  task automatic drain();
    int k = 0;
    grant = 1'b1;
    rx_ready = 1'b1;
    tx_valid = 1'b0;
    man_irq = 1'b0;
    while ((m_tx.size() != 0 || xfer_active || m_rx.size() != 0
            || busy) && k < 400) begin
      step(1);
      k++;
    end
    check("drain", k < 400, 1);
    rx_ready = 1'b0;
  endtask

  task automatic chk_rst(string p);
    check({p, "_tx_ready"}, tx_ready, 1);
    check({p, "_rx_valid"}, rx_valid, 0);
    check({p, "_rx_data"}, rx_data, 0);
    check({p, "_bus_req"}, bus_req, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_timeout"}, tmo, 0);
    check({p, "_we"}, we_l, 1);
    check({p, "_re"}, re_l, 1);
    check({p, "_addr"}, addr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s, g, n01, n02, r0, w0, a0, k, bz;
    step(3);
    chk_rst("reset");
    rst = 1'b0;
    step(2);

    // Single byte, grant tied high: latency of writes and read-back.
    grant = 1'b1;
    d_q = '{2};
    rd_q = '{8'h3C};
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    c = cyc;
    step(1);
    tx_valid = 1'b0;
    at_cycle(c + 9);
    check("t1_rx_valid_early", rx_valid, 0);
    at_cycle(c + 10);
    check("t1_rx_valid", rx_valid, 1);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_ff01_cycle", wr01_cyc, c + 3);
    check("t1_ff02_cycle", wr02_cyc, c + 4);
    step(1);
    drain();

    // Grant withheld in REQ_W, then dropped during WR_SC.
    grant = 1'b0;
    d_q = '{0};
    n01 = wr01_n;
    n02 = wr02_n;
    push(8'h5A);
    step(11);
    check("t2_req", bus_req, 1);
    check("t2_no_write", wr01_n, n01);
    grant = 1'b1;
    step(2);
    grant = 1'b0;
    g = cyc;
    step(3);
    grant = 1'b1;
    step(2);
    check("t2_ff01_once", wr01_n, n01 + 1);
    check("t2_ff02_once", wr02_n, n02 + 1);
    check("t2_ff02_cycle", wr02_cyc, g + 3);
    drain();

    // Timeout: the interrupt arrives one cycle too late.
    grant = 1'b1;
    rx_ready = 1'b0;
    d_q = '{TMO};
    r0 = tmo_n;
    n01 = rd_n;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    c = cyc;
    step(1);
    tx_valid = 1'b0;
    at_cycle(c + 5 + TMO - 1);
    check("t3_no_pulse_early", tmo, 0);
    at_cycle(c + 5 + TMO);
    check("t3_pulse", tmo, 1);
    check("t3_idle", busy, 0);
    step(6);
    check("t3_pulse_count", tmo_n, r0 + 1);
    check("t3_no_read", rd_n, n01);
    check("t3_rx_empty", rx_valid, 0);
    drain();

    // RX full blocks new transfers until a byte is consumed.
    grant = 1'b1;
    rx_ready = 1'b0;
    d_q = '{0, 0, 0, 0, 0};
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    k = 0;
    while ((m_rx.size() < DEPTH || busy) && k < 200) begin
      step(1);
      k++;
    end
    check("t4_rx_filled", m_rx.size(), DEPTH);
    push(8'hE5);
    r0 = req_n;
    w0 = wr01_n;
    step(10);
    check("t4_no_req", req_n, r0);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    k = 0;
    while (wr01_n == w0 && k < 20) begin
      step(1);
      k++;
    end
    check("t4_started", wr01_n, w0 + 1);
    drain();

    // TX full while stalled; fifth byte enters after the pop.
    grant = 1'b0;
    rx_ready = 1'b1;
    d_q = '{0, 0, 0, 0, 0};
    a0 = accepted;
    for (int i = 0; i < DEPTH; i++) push(8'(8'hC0 + i));
    check("t5_tx_full", tx_ready, 0);
    tx_data = 8'hC4;
    tx_valid = 1'b1;
    step(3);
    check("t5_held", accepted, a0 + DEPTH);
    grant = 1'b1;
    step(2);
    check("t5_not_yet", accepted, a0 + DEPTH);
    step(1);
    check("t5_fifth", accepted, a0 + DEPTH + 1);
    tx_valid = 1'b0;
    drain();

    // Reset while waiting for the interrupt.
    grant = 1'b1;
    rx_ready = 1'b0;
    d_q = '{0, 18};
    push(8'h11);
    k = 0;
    while ((m_rx.size() == 0 || busy) && k < 100) begin
      step(1);
      k++;
    end
    check("t6_first_rx", m_rx.size(), 1);
    n02 = wr02_n;
    push(8'h22);
    push(8'h33);
    k = 0;
    while (wr02_n == n02 && k < 50) begin
      step(1);
      k++;
    end
    step(3);
    check("t6_in_wait", busy && !bus_req, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_rst("t6");
    man_irq = 1'b1;
    step(1);
    man_irq = 1'b0;
    r0 = rd_n;
    bz = 0;
    repeat (20) begin
      step(1);
      if (busy) bz++;
    end
    check("t6_no_read", rd_n, r0);
    check("t6_stays_idle", bz, 0);

    // Random traffic against the model.
    d_q.delete();
    rd_q.delete();
    repeat (2500) begin
      grant = ($urandom_range(3, 0) != 0);
      tx_valid = $urandom_range(1, 0) != 0;
      tx_data = 8'($urandom);
      rx_ready = $urandom_range(1, 0) != 0;
      man_irq = !xfer_active && ($urandom_range(9, 0) == 0);
      step(1);
    end
    drain();
    step(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
